// File: rtl/asic_tester_pkg.sv
// rtl/asic_tester_pkg.sv - shared state encoding and timing defaults for the ASIC tester buffer controllers
package asic_tester_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    RESET_BUFFER = 2'd1,
    SHIFT        = 2'd2,
    LATCH        = 2'd3
  } buf_state_e;

  localparam int MAX_DELAY_DEF    = 40;
  localparam int SERIAL_LIMIT_DEF = 128;
  localparam int HALF_DELAY_DEF   = MAX_DELAY_DEF / 2;

  function automatic int half_phase(input int max_delay);
    return max_delay / 2;
  endfunction

endpackage

// File: rtl/input_buffer_ctrl_phase_timer.sv
// rtl/input_buffer_ctrl_phase_timer.sv - phase counter d (0..MAX_DELAY) with enable/clear and half/end flags
module phase_timer
  import asic_tester_pkg::*;
#(
  parameter int MAX_DELAY  = MAX_DELAY_DEF,
  parameter int HALF_DELAY = HALF_DELAY_DEF,
  parameter int D_W        = $clog2(MAX_DELAY + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic phase_end,
  output logic first_half_nxt
);

  logic [D_W-1:0] d_q, d_d;

  always_comb begin
    d_d = d_q;
    if (clr) begin
      d_d = '0;
    end else if (en) begin
      d_d = d_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= '0;
    end else begin
      d_q <= d_d;
    end
  end

  assign phase_end      = (d_q == D_W'(MAX_DELAY));
  // Pins are registered from the next count, so the half flag looks at d_d.
  assign first_half_nxt = (d_d < D_W'(HALF_DELAY));

endmodule

// File: rtl/input_buffer_ctrl.sv
// rtl/input_buffer_ctrl.sv - 74HC595 chain write controller; optional OE_BAR pin under INPUT_BUFFER_OE_EN
module input_buffer_ctrl
  import asic_tester_pkg::*;
#(
  parameter int MAX_DELAY    = MAX_DELAY_DEF,
  parameter int SERIAL_LIMIT = SERIAL_LIMIT_DEF
) (
  input  logic                    CLK,
  input  logic                    RST_BAR,
  input  logic                    CLEAR_BUFFER,
  input  logic                    LOAD_SRAM_DATA,
  input  logic [SERIAL_LIMIT-1:0] SRAM_DATA,
  output logic                    READY,
  output logic                    DS,
  output logic                    SHCP,
  output logic                    STCP,
`ifdef INPUT_BUFFER_OE_EN
  output logic                    MR_BAR,
  output logic                    OE_BAR
`else
  output logic                    MR_BAR
`endif
);

  localparam int BIDX_W = $clog2(SERIAL_LIMIT);
  localparam int BIT_W  = BIDX_W + 1;
  localparam int HALF   = half_phase(MAX_DELAY);

  buf_state_e              state_q, state_d;
  logic [BIT_W-1:0]        b_q, b_d;
  logic [SERIAL_LIMIT-1:0] shadow_q, shadow_d;
  logic                    ready_q, ready_d;
  logic                    ds_q, ds_d;
  logic                    shcp_q, shcp_d;
  logic                    stcp_q, stcp_d;
  logic                    mr_bar_q, mr_bar_d;
  logic                    timer_en, timer_clr;
  logic                    phase_end, first_half_nxt;
  logic [BIDX_W-1:0]       bit_idx;

  phase_timer #(
    .MAX_DELAY  (MAX_DELAY),
    .HALF_DELAY (HALF)
  ) u_phase_timer (
    .clk            (CLK),
    .rst_n          (RST_BAR),
    .en             (timer_en),
    .clr            (timer_clr),
    .phase_end      (phase_end),
    .first_half_nxt (first_half_nxt)
  );

  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    shadow_d  = shadow_q;
    timer_en  = 1'b0;
    timer_clr = 1'b1;
    case (state_q)
      IDLE: begin
        b_d = '0;
        if (CLEAR_BUFFER) begin
          state_d = RESET_BUFFER;
        end else if (LOAD_SRAM_DATA) begin
          shadow_d = SRAM_DATA;
          state_d  = SHIFT;
        end
      end
      RESET_BUFFER: begin
        timer_en  = 1'b1;
        timer_clr = phase_end;
        if (phase_end) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        timer_en  = 1'b1;
        timer_clr = phase_end;
        if (phase_end) begin
          // b reaches SERIAL_LIMIT on the last bit and is only cleared in IDLE.
          b_d = b_q + 1'b1;
          if (b_q == BIT_W'(SERIAL_LIMIT - 1)) begin
            state_d = LATCH;
          end
        end
      end
      LATCH: begin
        timer_en  = 1'b1;
        timer_clr = phase_end;
        if (phase_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bit_idx  = BIDX_W'(SERIAL_LIMIT - 1 - int'(b_d));
    ready_d  = (state_d == IDLE);
    mr_bar_d = !((state_d == RESET_BUFFER) && first_half_nxt);
    shcp_d   = (state_d == SHIFT) && !first_half_nxt;
    stcp_d   = (state_d == LATCH) && !first_half_nxt;
    ds_d     = (state_d == SHIFT) ? shadow_d[bit_idx] : 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_BAR) begin
    if (!RST_BAR) begin
      state_q  <= IDLE;
      b_q      <= '0;
      shadow_q <= '0;
      ready_q  <= 1'b1;
      ds_q     <= 1'b0;
      shcp_q   <= 1'b0;
      stcp_q   <= 1'b0;
      mr_bar_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      shadow_q <= shadow_d;
      ready_q  <= ready_d;
      ds_q     <= ds_d;
      shcp_q   <= shcp_d;
      stcp_q   <= stcp_d;
      mr_bar_q <= mr_bar_d;
    end
  end

  assign READY  = ready_q;
  assign DS     = ds_q;
  assign SHCP   = shcp_q;
  assign STCP   = stcp_q;
  assign MR_BAR = mr_bar_q;

`ifdef INPUT_BUFFER_OE_EN
  logic oe_bar_q, oe_bar_d;

  // Outputs stay disabled from a chain reset until a full load has been latched.
  always_comb begin
    oe_bar_d = oe_bar_q;
    if ((state_q == IDLE) && (state_d == RESET_BUFFER)) begin
      oe_bar_d = 1'b1;
    end else if ((state_q == LATCH) && (state_d == IDLE)) begin
      oe_bar_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_BAR) begin
    if (!RST_BAR) begin
      oe_bar_q <= 1'b1;
    end else begin
      oe_bar_q <= oe_bar_d;
    end
  end

  assign OE_BAR = oe_bar_q;
`endif

endmodule

// File: tb/tb_input_buffer_ctrl.sv
// tb/tb_input_buffer_ctrl.sv - randomized bench with a behavioural 128-bit 595 chain model
module tb_input_buffer_ctrl;

  localparam int MD        = 40;
  localparam int SL        = 128;
  localparam int PHASE     = MD + 1;
  localparam int BUSY_CLR  = PHASE;
  localparam int BUSY_LOAD = SL * PHASE + PHASE;

  logic          CLK;
  logic          RST_BAR;
  logic          CLEAR_BUFFER;
  logic          LOAD_SRAM_DATA;
  logic [SL-1:0] SRAM_DATA;
  logic          READY, DS, SHCP, STCP, MR_BAR;
`ifdef INPUT_BUFFER_OE_EN
  logic          OE_BAR;
`endif

  input_buffer_ctrl dut (
    .CLK            (CLK),
    .RST_BAR        (RST_BAR),
    .CLEAR_BUFFER   (CLEAR_BUFFER),
    .LOAD_SRAM_DATA (LOAD_SRAM_DATA),
    .SRAM_DATA      (SRAM_DATA),
    .READY          (READY),
    .DS             (DS),
    .SHCP           (SHCP),
`ifdef INPUT_BUFFER_OE_EN
    .STCP           (STCP),
    .MR_BAR         (MR_BAR),
    .OE_BAR         (OE_BAR)
`else
    .STCP           (STCP),
    .MR_BAR         (MR_BAR)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [SL-1:0] got, input logic [SL-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural 595 chain: sr[i] is register i, register 0 nearest the controller.
  logic [SL-1:0] sr = '0;
  logic [SL-1:0] latch = '0;
  logic [SL-1:0] ds_word = '0;
  logic shcp_prev = 1'b0, stcp_prev = 1'b0;
  int cyc = 0, last_rise = 0;
  int shcp_rises = 0, stcp_high = 0, mr_low = 0, gap_err = 0, idle_viol = 0, oe_low_busy = 0;

  always @(negedge CLK) begin
    cyc++;
    if (!MR_BAR) begin
      sr = '0;
      mr_low++;
    end
    if (SHCP && !shcp_prev) begin
      sr      = {sr[SL-2:0], DS};
      ds_word = {ds_word[SL-2:0], DS};
      if (shcp_rises != 0 && (cyc - last_rise) != PHASE) gap_err++;
      last_rise = cyc;
      shcp_rises++;
    end
    if (STCP && !stcp_prev) latch = sr;
    if (STCP) stcp_high++;
    if (READY && (DS || SHCP || STCP || !MR_BAR)) idle_viol++;
`ifdef INPUT_BUFFER_OE_EN
    if (!READY && !OE_BAR) oe_low_busy++;
`endif
    shcp_prev = SHCP;
    stcp_prev = STCP;
  end

  task automatic clear_stats();
    shcp_rises  = 0;
    stcp_high   = 0;
    mr_low      = 0;
    gap_err     = 0;
    idle_viol   = 0;
    oe_low_busy = 0;
    ds_word     = '0;
  endtask

  task automatic run_op(input logic clr, input logic ld, input logic [SL-1:0] data,
                        input bit wiggle, output int busy);
    CLEAR_BUFFER   = clr;
    LOAD_SRAM_DATA = ld;
    SRAM_DATA      = data;
    @(posedge CLK); #1;
    CLEAR_BUFFER   = 1'b0;
    LOAD_SRAM_DATA = 1'b0;
    busy = 0;
    while (!READY && busy < 6000) begin
      if (wiggle) begin
        SRAM_DATA      = {$urandom, $urandom, $urandom, $urandom};
        CLEAR_BUFFER   = 1'($urandom_range(0, 1));
        LOAD_SRAM_DATA = 1'($urandom_range(0, 1));
      end
      @(posedge CLK); #1;
      busy++;
    end
    CLEAR_BUFFER   = 1'b0;
    LOAD_SRAM_DATA = 1'b0;
  endtask

  logic [SL-1:0] exp_latch;
  logic [SL-1:0] w;
  logic [SL-1:0] pat_a5;
  int busy;
  int wait_cnt;
  int op;

  initial begin
    RST_BAR        = 1'b0;
    CLEAR_BUFFER   = 1'b0;
    LOAD_SRAM_DATA = 1'b0;
    SRAM_DATA      = '0;
    exp_latch      = '0;
    pat_a5         = {16{8'hA5}};
    repeat (3) @(posedge CLK);
    #1 RST_BAR = 1'b1;
    clear_stats();
    repeat (100) @(posedge CLK);
    #1;
    check("idle_outputs", SL'(idle_viol), SL'(0));
    check("idle_ready", SL'(READY), SL'(1));
`ifdef INPUT_BUFFER_OE_EN
    check("oe_after_reset", SL'(OE_BAR), SL'(1));
`endif

    clear_stats();
    run_op(1'b1, 1'b0, '0, 1'b0, busy);
    check("clr_busy", SL'(busy), SL'(BUSY_CLR));
    check("clr_mr_low", SL'(mr_low), SL'(MD / 2));
    check("clr_shcp", SL'(shcp_rises), SL'(0));
    check("clr_stcp", SL'(stcp_high), SL'(0));

    w = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    clear_stats();
    run_op(1'b0, 1'b1, w, 1'b0, busy);
    exp_latch = w;
    check("load_busy", SL'(busy), SL'(BUSY_LOAD));
    check("load_shcp_rises", SL'(shcp_rises), SL'(SL));
    check("load_shcp_gap", SL'(gap_err), SL'(0));
    check("load_stcp_high", SL'(stcp_high), SL'(MD - MD / 2 + 1));
    check("load_ds_seq", ds_word, w);
    check("load_latch", latch, exp_latch);
    check("load_idle_outputs", SL'(idle_viol), SL'(0));
`ifdef INPUT_BUFFER_OE_EN
    check("load_oe", SL'(OE_BAR), SL'(0));
`endif

    clear_stats();
    run_op(1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, busy);
    check("both_busy", SL'(busy), SL'(BUSY_CLR));
    check("both_mr_low", SL'(mr_low), SL'(MD / 2));
    check("both_shcp", SL'(shcp_rises), SL'(0));
    check("both_latch", latch, exp_latch);
`ifdef INPUT_BUFFER_OE_EN
    check("both_oe", SL'(OE_BAR), SL'(1));
`endif

    w = {$urandom, $urandom, $urandom, $urandom};
    clear_stats();
    run_op(1'b0, 1'b1, w, 1'b1, busy);
    exp_latch = w;
    check("wiggle_busy", SL'(busy), SL'(BUSY_LOAD));
    check("wiggle_latch", latch, exp_latch);

    // Asynchronous reset in the middle of a shift.
    clear_stats();
    SRAM_DATA      = {$urandom, $urandom, $urandom, $urandom};
    LOAD_SRAM_DATA = 1'b1;
    @(posedge CLK); #1;
    LOAD_SRAM_DATA = 1'b0;
    wait_cnt = 0;
    while (shcp_rises < 60 && wait_cnt < 3000) begin
      @(posedge CLK); #1;
      wait_cnt++;
    end
    check("reach_bit60", SL'(shcp_rises), SL'(60));
    #2 RST_BAR = 1'b0;
    #1;
    check("arst_ready", SL'(READY), SL'(1));
    check("arst_ds", SL'(DS), SL'(0));
    check("arst_shcp", SL'(SHCP), SL'(0));
    check("arst_stcp", SL'(STCP), SL'(0));
    check("arst_mr_bar", SL'(MR_BAR), SL'(1));
`ifdef INPUT_BUFFER_OE_EN
    check("arst_oe", SL'(OE_BAR), SL'(1));
`endif
    @(posedge CLK); #1;
    RST_BAR = 1'b1;
    check("arst_latch_held", latch, exp_latch);

    clear_stats();
    run_op(1'b0, 1'b1, pat_a5, 1'b0, busy);
    exp_latch = pat_a5;
    check("a5_busy", SL'(busy), SL'(BUSY_LOAD));
    check("a5_latch", latch, exp_latch);
`ifdef INPUT_BUFFER_OE_EN
    check("a5_oe_busy", SL'(oe_low_busy), SL'(0));
    check("a5_oe_end", SL'(OE_BAR), SL'(0));
`endif

    for (int i = 0; i < 4; i++) begin
      op = int'($urandom_range(0, 3));
      w  = {$urandom, $urandom, $urandom, $urandom};
      clear_stats();
      if (op == 0) begin
        run_op(1'b1, 1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), busy);
        check("rnd_clr_busy", SL'(busy), SL'(BUSY_CLR));
        check("rnd_clr_mr_low", SL'(mr_low), SL'(MD / 2));
`ifdef INPUT_BUFFER_OE_EN
        check("rnd_clr_oe", SL'(OE_BAR), SL'(1));
`endif
      end else begin
        run_op(1'b0, 1'b1, w, 1'($urandom_range(0, 1)), busy);
        exp_latch = w;
        check("rnd_load_busy", SL'(busy), SL'(BUSY_LOAD));
        check("rnd_load_gap", SL'(gap_err), SL'(0));
`ifdef INPUT_BUFFER_OE_EN
        check("rnd_load_oe", SL'(OE_BAR), SL'(0));
`endif
      end
      check("rnd_latch", latch, exp_latch);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
